// File: rtl/ir_obstacle_debounce_pkg.sv
// Shared constants for the IR obstacle debouncer: FSM state encoding and pin-level helper.
package ir_pkg;

  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] Q_SET = 2'd1;
  localparam logic [1:0] SET   = 2'd2;
  localparam logic [1:0] Q_CLR = 2'd3;

  typedef enum logic [1:0] {
    ST_CLEAR = CLEAR,
    ST_Q_SET = Q_SET,
    ST_SET   = SET,
    ST_Q_CLR = Q_CLR
  } ir_state_e;

  // Pin level that means "no obstacle" for the given sensor polarity.
  function automatic logic IR_INACTIVE_LVL(input int unsigned active_low);
    return (active_low != 0);
  endfunction

endpackage

// File: rtl/ir_obstacle_debounce_if.sv
// Sensor-side bundle of the IR debouncer: raw pin in, debounced level, edge pulses and event counter out.
interface ir_obstacle_debounce_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ir_raw;
  logic             event_clr;
  logic             obstacle;
  logic             obstacle_rise;
  logic             obstacle_fall;
  logic [CNT_W-1:0] event_count;

  modport master (
    output ir_raw, event_clr,
    input  obstacle, obstacle_rise, obstacle_fall, event_count
  );

  modport slave (
    input  ir_raw, event_clr,
    output obstacle, obstacle_rise, obstacle_fall, event_count
  );
endinterface

// File: rtl/ir_obstacle_debounce_sync_chain.sv
// Plain flop chain bringing the asynchronous sensor pin into the clk domain.
module ir_sync_chain #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {STAGES{RST_VAL}};
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ir_obstacle_debounce.sv
// IR obstacle conditioner: synchroniser, debounce FSM, registered edge pulses.
// Optional saturating detection counter built when IR_EVENT_COUNT_EN is defined.
module ir_obstacle_debounce
  import ir_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned CNT_W           = 16
) (
  input logic                 clk,
  input logic                 rst,
  ir_obstacle_debounce_if.slave bus
);

  localparam int unsigned    DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic           RST_LVL = IR_INACTIVE_LVL(ACTIVE_LOW);

  logic      sync_lvl;
  logic      s_c;
  ir_state_e state_q, state_nx;
  logic [DB_W-1:0] cnt_q, cnt_nx;
  logic      obstacle_q, obstacle_nx;
  logic      rise_q, rise_nx;
  logic      fall_q, fall_nx;

  ir_sync_chain #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (RST_LVL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.ir_raw),
    .q   (sync_lvl)
  );

  // Normalise polarity so s_c=1 always means obstacle.
  assign s_c = sync_lvl ^ RST_LVL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = '0;
    unique case (state_q)
      ST_CLEAR: begin
        if (s_c) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nx = ST_SET;
          end else begin
            state_nx = ST_Q_SET;
            cnt_nx   = DB_W'(1);
          end
        end
      end
      ST_Q_SET: begin
        if (!s_c)                  state_nx = ST_CLEAR;
        else if (cnt_q == DB_LAST) state_nx = ST_SET;
        else                       cnt_nx   = cnt_q + DB_W'(1);
      end
      ST_SET: begin
        if (!s_c) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nx = ST_CLEAR;
          end else begin
            state_nx = ST_Q_CLR;
            cnt_nx   = DB_W'(1);
          end
        end
      end
      ST_Q_CLR: begin
        if (s_c)                   state_nx = ST_SET;
        else if (cnt_q == DB_LAST) state_nx = ST_CLEAR;
        else                       cnt_nx   = cnt_q + DB_W'(1);
      end
      default: state_nx = ST_CLEAR;
    endcase

    // Obstacle stays asserted while a clear is still being qualified.
    obstacle_nx = (state_nx == ST_SET) || (state_nx == ST_Q_CLR);
    rise_nx     = obstacle_nx & ~obstacle_q;
    fall_nx     = ~obstacle_nx & obstacle_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obstacle_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      obstacle_q <= obstacle_nx;
      rise_q     <= rise_nx;
      fall_q     <= fall_nx;
    end
  end

  assign bus.obstacle      = obstacle_q;
  assign bus.obstacle_rise = rise_q;
  assign bus.obstacle_fall = fall_q;

`ifdef IR_EVENT_COUNT_EN
  logic [CNT_W-1:0] evt_q;

  // Counts the rise pulse in the cycle it is visible; a clear in that cycle keeps it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          evt_q <= '0;
    else if (bus.event_clr)           evt_q <= CNT_W'(rise_q);
    else if (rise_q && (evt_q != '1)) evt_q <= evt_q + CNT_W'(1);
  end

  assign bus.event_count = evt_q;
`else
  logic unused_event_clr;

  assign unused_event_clr = bus.event_clr;
  assign bus.event_count  = '0;
`endif

endmodule

// File: tb/tb_ir_obstacle_debounce.sv
// Self-checking bench for ir_obstacle_debounce: directed tables, corner sequences and
// randomized pin activity against a run-length reference model.
module tb_ir_obstacle_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ir_obstacle_debounce_if #(.CNT_W(16)) bus0 ();
  ir_obstacle_debounce_if #(.CNT_W(2))  bus1 ();

  ir_obstacle_debounce #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .ACTIVE_LOW(1), .CNT_W(16)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  ir_obstacle_debounce #(
    .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .ACTIVE_LOW(0), .CNT_W(2)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: debounced level flips once DC consecutive samples disagree with it.
  typedef struct {
    int     stages;
    int     dc;
    bit     al;
    int     cw;
    bit     hist[8];
    int     run;
    bit     lvl;
    bit     rise;
    bit     fall;
    longint cnt;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_reset(mdl_t m);
    for (int i = 0; i < 8; i++) m.hist[i] = m.al;
    m.run  = 0;
    m.lvl  = 0;
    m.rise = 0;
    m.fall = 0;
    m.cnt  = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit raw, bit clr);
    bit s;
`ifdef IR_EVENT_COUNT_EN
    if (clr)                                        m.cnt = m.rise ? 1 : 0;
    else if (m.rise && m.cnt < (64'd1 << m.cw) - 1) m.cnt = m.cnt + 1;
`endif
    s      = m.hist[m.stages-1] ^ m.al;
    m.rise = 0;
    m.fall = 0;
    if (s != m.lvl) begin
      m.run = m.run + 1;
      if (m.run >= m.dc) begin
        m.lvl  = s;
        m.run  = 0;
        m.rise = s;
        m.fall = !s;
      end
    end else begin
      m.run = 0;
    end
    for (int i = 7; i > 0; i--) m.hist[i] = m.hist[i-1];
    m.hist[0] = raw;
    return m;
  endfunction

  function automatic longint exp_evt(longint n);
`ifdef IR_EVENT_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      m0 = mdl_reset(m0);
      m1 = mdl_reset(m1);
    end else begin
      m0 = mdl_step(m0, bus0.ir_raw, bus0.event_clr);
      m1 = mdl_step(m1, bus1.ir_raw, bus1.event_clr);
    end
    #1;
    chk("obs0",  bus0.obstacle,      m0.lvl);
    chk("rise0", bus0.obstacle_rise, m0.rise);
    chk("fall0", bus0.obstacle_fall, m0.fall);
    chk("cnt0",  bus0.event_count,   m0.cnt);
    chk("obs1",  bus1.obstacle,      m1.lvl);
    chk("rise1", bus1.obstacle_rise, m1.rise);
    chk("fall1", bus1.obstacle_fall, m1.fall);
    chk("cnt1",  bus1.event_count,   m1.cnt);
  endtask

  task automatic hold0(input bit raw, input int n);
    bus0.ir_raw = raw;
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    bit raw;
    bit exp_obs;
    bit exp_rise;
    bit exp_fall;
  } vec_t;

  vec_t tv[12];

  task automatic run_table(input string nm);
    for (int i = 0; i < 12; i++) begin
      bus0.ir_raw = tv[i].raw;
      step();
      chk({nm, "_obs"},  bus0.obstacle,      tv[i].exp_obs);
      chk({nm, "_rise"}, bus0.obstacle_rise, tv[i].exp_rise);
      chk({nm, "_fall"}, bus0.obstacle_fall, tv[i].exp_fall);
    end
  endtask

  initial begin
    int h0, h1;
    m0.stages = 2; m0.dc = 8; m0.al = 1; m0.cw = 16;
    m1.stages = 3; m1.dc = 1; m1.al = 0; m1.cw = 2;
    m0 = mdl_reset(m0);
    m1 = mdl_reset(m1);
    bus0.ir_raw = 1'b1; bus0.event_clr = 1'b0;
    bus1.ir_raw = 1'b0; bus1.event_clr = 1'b0;

    // Reset, then idle pin for 50 cycles.
    #1;
    chk("rst_obs",  bus0.obstacle, 0);
    chk("rst_rise", bus0.obstacle_rise, 0);
    chk("rst_cnt",  bus0.event_count, 0);
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_obs",  bus0.obstacle, 0);
      chk("idle_fall", bus0.obstacle_fall, 0);
    end

    // Held detection: level and rise appear on edge 10 only.
    for (int i = 0; i < 12; i++) begin
      tv[i].raw      = 1'b0;
      tv[i].exp_obs  = (i + 1 >= 10);
      tv[i].exp_rise = (i + 1 == 10);
      tv[i].exp_fall = 1'b0;
    end
    run_table("set");

    // Held release: single fall pulse on edge 10; count unchanged by a fall.
    for (int i = 0; i < 12; i++) begin
      tv[i].raw      = 1'b1;
      tv[i].exp_obs  = (i + 1 < 10);
      tv[i].exp_rise = 1'b0;
      tv[i].exp_fall = (i + 1 == 10);
    end
    run_table("clr");
    chk("cnt_after_fall", bus0.event_count, exp_evt(1));

    // Seven agreeing samples then a glitch back: no output change.
    bus0.ir_raw = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 7) bus0.ir_raw = 1'b1;
      step();
      chk("abort_obs",  bus0.obstacle, 0);
      chk("abort_rise", bus0.obstacle_rise, 0);
    end
    bus0.ir_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 9)  chk("requal_e9",  bus0.obstacle, 0);
      if (i == 10) chk("requal_e10", bus0.obstacle_rise, 1);
    end
    step();

    // Reset mid-qualification discards progress.
    hold0(1'b1, 12);
    hold0(1'b0, 5);
    rst = 1'b1;
    #1;
    chk("midrst_obs",  bus0.obstacle, 0);
    chk("midrst_rise", bus0.obstacle_rise, 0);
    chk("midrst_fall", bus0.obstacle_fall, 0);
    chk("midrst_cnt",  bus0.event_count, 0);
    step(); step();
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 9)  chk("postrst_e9",  bus0.obstacle, 0);
      if (i == 10) chk("postrst_e10", bus0.obstacle, 1);
    end
    step();

    // Two more detections, then a clear in the rise cycle.
    for (int k = 0; k < 2; k++) begin
      hold0(1'b1, 12);
      hold0(1'b0, 11);
    end
    chk("cnt_three", bus0.event_count, exp_evt(3));
    hold0(1'b1, 12);
    hold0(1'b0, 10);
    chk("clr_rise_seen", bus0.obstacle_rise, 1);
    bus0.event_clr = 1'b1;
    step();
    bus0.event_clr = 1'b0;
    chk("clr_with_rise", bus0.event_count, exp_evt(1));

    // DEBOUNCE_CYCLES=1 instance: latency 4 edges, then saturation at 3.
    for (int k = 0; k < 5; k++) begin
      bus1.ir_raw = 1'b1;
      for (int i = 1; i <= 6; i++) begin
        step();
        if (k == 0 && i == 3) chk("dc1_e3", bus1.obstacle, 0);
        if (k == 0 && i == 4) chk("dc1_e4", bus1.obstacle_rise, 1);
      end
      bus1.ir_raw = 1'b0;
      for (int i = 0; i < 6; i++) step();
    end
    chk("sat_cnt", bus1.event_count, exp_evt(3));

    // Randomized pin activity with occasional clears and resets.
    h0 = 1; h1 = 1;
    for (int i = 0; i < 3000; i++) begin
      if (--h0 == 0) begin
        bus0.ir_raw = 1'($urandom & 1);
        h0 = $urandom_range(1, 12);
      end
      if (--h1 == 0) begin
        bus1.ir_raw = 1'($urandom & 1);
        h1 = $urandom_range(1, 4);
      end
      bus0.event_clr = ($urandom_range(0, 31) == 0);
      bus1.event_clr = ($urandom_range(0, 31) == 0);
      if (rst)                                rst = 1'b0;
      else if ($urandom_range(0, 499) == 0)   rst = 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
